// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_pkg
//  Purpose  : Shared definitions for the multicycle control sequencer.
//             Provides the state encoding, opcode/funct values, ALUControl
//             encodings and the datapath mux-select constants.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_START    = 5'd0,
    S_FETCH    = 5'd1,
    S_DECODE   = 5'd2,
    S_EXEC_R   = 5'd3,
    S_R_WB     = 5'd4,
    S_EXEC_I   = 5'd5,
    S_I_WB     = 5'd6,
    S_MEMADR   = 5'd7,
    S_MEMRD    = 5'd8,
    S_MEMWB    = 5'd9,
    S_MEMWR    = 5'd10,
    S_BR_CMP   = 5'd11,
    S_BR_TGT   = 5'd12,
    S_JUMP     = 5'd13,
    S_JR       = 5'd14,
    S_JAL_LINK = 5'd15,
    S_ILLEGAL  = 5'd16
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_NORI  = 6'b001110;
  localparam logic [5:0] C_OP_BLEU  = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_JAL   = 6'b000011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] C_FN_ADD  = 6'b100000;
  localparam logic [5:0] C_FN_AND  = 6'b100100;
  localparam logic [5:0] C_FN_NOR  = 6'b100111;
  localparam logic [5:0] C_FN_NOT  = 6'b100101;
  localparam logic [5:0] C_FN_ROLV = 6'b000100;
  localparam logic [5:0] C_FN_RORV = 6'b000110;
  localparam logic [5:0] C_FN_JR   = 6'b001000;

  // ALUControl encodings
  localparam logic [4:0] C_ALU_ADD   = 5'b00000;
  localparam logic [4:0] C_ALU_AND   = 5'b00001;
  localparam logic [4:0] C_ALU_NOR   = 5'b00010;
  localparam logic [4:0] C_ALU_NOT   = 5'b00011;
  localparam logic [4:0] C_ALU_NORI  = 5'b00100;
  localparam logic [4:0] C_ALU_ROLV  = 5'b00101;
  localparam logic [4:0] C_ALU_RORV  = 5'b00110;
  localparam logic [4:0] C_ALU_BLEU  = 5'b00111;
  localparam logic [4:0] C_ALU_PASSA = 5'b01000;

  // ALUSrcB selects
  localparam logic [1:0] C_SRCB_RD2     = 2'b00;
  localparam logic [1:0] C_SRCB_FOUR    = 2'b01;
  localparam logic [1:0] C_SRCB_IMM     = 2'b10;
  localparam logic [1:0] C_SRCB_IMM_SH2 = 2'b11;

  // PCSrc selects
  localparam logic [1:0] C_PCSRC_ALU  = 2'b00;
  localparam logic [1:0] C_PCSRC_JUMP = 2'b10;

  // Registered control word; 'fetch' marks the FETCH state so the
  // memory-ready gated enables can be formed at the output.
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       jump_reg;
    logic       jump;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic [4:0] alu_ctrl;
    logic       illegal;
    logic       fetch;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mc_ctrl_decode
//  Purpose  : Combinational instruction dispatch. Maps opcode/funct to the
//             state that follows DECODE, the ALU operation for the execute
//             phase, and whether a memory op is a store. Undefined
//             opcode/funct combinations dispatch to ILLEGAL.
//  Ports    : opcode_i     - instr[31:26]
//             funct_i      - instr[5:0]
//             next_state_o - dispatch target
//             alu_op_o     - ALUControl for the execute phase
//             is_store_o   - 1 for sw, 0 otherwise
//  Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output state_e     next_state_o,
  output logic [4:0] alu_op_o,
  output logic       is_store_o
);

  always_comb begin
    next_state_o = S_ILLEGAL;
    alu_op_o     = C_ALU_ADD;
    is_store_o   = 1'b0;
    case (opcode_i)
      C_OP_RTYPE: begin
        next_state_o = S_EXEC_R;
        case (funct_i)
          C_FN_ADD:  alu_op_o = C_ALU_ADD;
          C_FN_AND:  alu_op_o = C_ALU_AND;
          C_FN_NOR:  alu_op_o = C_ALU_NOR;
          C_FN_NOT:  alu_op_o = C_ALU_NOT;
          C_FN_ROLV: alu_op_o = C_ALU_ROLV;
          C_FN_RORV: alu_op_o = C_ALU_RORV;
          C_FN_JR:   next_state_o = S_JR;
          default:   next_state_o = S_ILLEGAL;
        endcase
      end
      C_OP_LW:   next_state_o = S_MEMADR;
      C_OP_SW: begin
        next_state_o = S_MEMADR;
        is_store_o   = 1'b1;
      end
      C_OP_NORI: begin
        next_state_o = S_EXEC_I;
        alu_op_o     = C_ALU_NORI;
      end
      C_OP_BLEU: begin
        next_state_o = S_BR_CMP;
        alu_op_o     = C_ALU_BLEU;
      end
      C_OP_J:    next_state_o = S_JUMP;
      C_OP_JAL: begin
        next_state_o = S_JAL_LINK;
        alu_op_o     = C_ALU_PASSA;
      end
      default:   next_state_o = S_ILLEGAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control_fsm
//  Purpose  : Moore sequencer for the multicycle single-memory datapath.
//             Steps fetch/decode/execute/memory/writeback and drives all
//             datapath selects and write enables from registered state.
//  Ports    : clock, reset_n           - clock / async active-low reset
//             instr                    - IR contents
//             mem_ready                - memory access completed this cycle
//             branch_cond              - ALU compare result (BR_CMP only)
//             PCWrite..ALUControl      - datapath controls
//             illegal                  - one-cycle undefined-instr pulse
//             retired                  - completed-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  input  logic                branch_cond,
  output logic                PCWrite,
  output logic                IorD,
  output logic                IRWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic                jumpReg,
  output logic                jump,
  output logic                regDst,
  output logic                memToReg,
  output logic                regWriteEnable,
  output logic                memWrite,
  output logic [4:0]          ALUControl,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_e              state_q, state_d;
  ctrl_t               ctrl_q;
  logic [4:0]          rop_q;      // ALU op latched at DECODE for R-type
  logic                store_q;    // sw vs lw, latched at DECODE
  logic [RETIRE_W-1:0] retired_q;

  state_e              dec_next;
  logic [4:0]          dec_alu;
  logic                dec_store;
  logic [4:0]          alu_r;
  logic                retire;
  logic                unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  mc_ctrl_decode u_decode (
    .opcode_i     (instr[31:26]),
    .funct_i      (instr[5:0]),
    .next_state_o (dec_next),
    .alu_op_o     (dec_alu),
    .is_store_o   (dec_store)
  );

  // Control word for a given state. The BR_TGT PCWrite bit is loaded from
  // branch_cond while leaving BR_CMP, so the register holds the taken flag.
  function automatic ctrl_t ctrl_for(state_e s, logic [4:0] rop, logic taken);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch = 1'b1; c.alu_src_b = C_SRCB_FOUR; c.alu_ctrl = C_ALU_ADD;
      end
      S_EXEC_R, S_R_WB: begin
        c.alu_src_a = 1'b1; c.alu_src_b = C_SRCB_RD2; c.alu_ctrl = rop;
        c.reg_dst   = (s == S_R_WB);
        c.reg_write = (s == S_R_WB);
      end
      S_EXEC_I, S_I_WB: begin
        c.alu_src_a = 1'b1; c.alu_src_b = C_SRCB_IMM; c.alu_ctrl = C_ALU_NORI;
        c.reg_write = (s == S_I_WB);
      end
      S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR: begin
        c.alu_src_a  = 1'b1; c.alu_src_b = C_SRCB_IMM; c.alu_ctrl = C_ALU_ADD;
        c.iord       = (s != S_MEMADR);
        c.mem_to_reg = (s == S_MEMWB);
        c.reg_write  = (s == S_MEMWB);
        c.mem_write  = (s == S_MEMWR);
      end
      S_BR_CMP: begin
        c.alu_src_a = 1'b1; c.alu_src_b = C_SRCB_RD2; c.alu_ctrl = C_ALU_BLEU;
      end
      S_BR_TGT: begin
        c.alu_src_b = C_SRCB_IMM_SH2; c.alu_ctrl = C_ALU_ADD;
        c.pc_src    = C_PCSRC_ALU;    c.pc_write = taken;
      end
      S_JUMP, S_JR: begin
        c.pc_src   = C_PCSRC_JUMP; c.pc_write = 1'b1;
        c.jump_reg = (s == S_JR);
      end
      S_JAL_LINK: begin
        c.alu_ctrl = C_ALU_PASSA; c.jump = 1'b1; c.reg_write = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:    state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = dec_next;
      S_EXEC_R:   state_d = S_R_WB;
      S_EXEC_I:   state_d = S_I_WB;
      S_MEMADR:   state_d = store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_BR_CMP:   state_d = S_BR_TGT;
      S_JAL_LINK: state_d = S_JUMP;
      S_R_WB, S_I_WB, S_MEMWB, S_BR_TGT, S_JUMP, S_JR, S_ILLEGAL:
                  state_d = S_FETCH;
      default:    state_d = S_START;
    endcase
  end

  // R-type ops use the freshly decoded funct on entry and the latched copy after.
  assign alu_r  = (state_q == S_DECODE) ? dec_alu : rop_q;
  assign retire = (state_d == S_FETCH) &&
                  !(state_q inside {S_START, S_ILLEGAL, S_FETCH});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_START;
      ctrl_q    <= '0;
      rop_q     <= C_ALU_ADD;
      store_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_for(state_d, alu_r, branch_cond);
      if (state_q == S_DECODE) begin
        rop_q   <= dec_alu;
        store_q <= dec_store;
      end
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  // PC/IR loads in FETCH must coincide with the cycle memory completes.
  assign PCWrite        = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready);
  assign IRWrite        = ctrl_q.fetch & mem_ready;
  assign IorD           = ctrl_q.iord;
  assign ALUSrcA        = ctrl_q.alu_src_a;
  assign ALUSrcB        = ctrl_q.alu_src_b;
  assign PCSrc          = ctrl_q.pc_src;
  assign jumpReg        = ctrl_q.jump_reg;
  assign jump           = ctrl_q.jump;
  assign regDst         = ctrl_q.reg_dst;
  assign memToReg       = ctrl_q.mem_to_reg;
  assign regWriteEnable = ctrl_q.reg_write;
  assign memWrite       = ctrl_q.mem_write;
  assign ALUControl     = ctrl_q.alu_ctrl;
  assign illegal        = ctrl_q.illegal;
  assign retired        = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control_fsm
//  Purpose  : Scoreboard bench for multicycle_control_fsm (RETIRE_W = 4).
//             Stimulus pushes the expected control word per cycle; a monitor
//             on the falling edge pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        mem_ready, branch_cond;
  logic        PCWrite, IorD, IRWrite, ALUSrcA, jumpReg, jump;
  logic        regDst, memToReg, regWriteEnable, memWrite, illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [4:0]  ALUControl;
  logic [3:0]  retired;

  multicycle_control_fsm #(.RETIRE_W(4)) dut (
    .clock(clk), .reset_n(reset_n), .instr(instr), .mem_ready(mem_ready),
    .branch_cond(branch_cond), .PCWrite(PCWrite), .IorD(IorD),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .jumpReg(jumpReg), .jump(jump), .regDst(regDst), .memToReg(memToReg),
    .regWriteEnable(regWriteEnable), .memWrite(memWrite),
    .ALUControl(ALUControl), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] ctl;
    logic [3:0]  ret;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Field order: PCWrite IorD IRWrite ALUSrcA ALUSrcB PCSrc jumpReg jump
  //              regDst memToReg regWriteEnable memWrite ALUControl illegal
  function automatic logic [19:0] mk(logic pcw, logic iord, logic irw,
      logic a, logic [1:0] b, logic [1:0] pcs, logic jr, logic j, logic rd,
      logic m2r, logic rwe, logic mw, logic [4:0] alu, logic ill);
    return {pcw, iord, irw, a, b, pcs, jr, j, rd, m2r, rwe, mw, alu, ill};
  endfunction

  function automatic logic [19:0] act_ctl();
    return {PCWrite, IorD, IRWrite, ALUSrcA, ALUSrcB, PCSrc, jumpReg, jump,
            regDst, memToReg, regWriteEnable, memWrite, ALUControl, illegal};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act_ctl() !== e.ctl || retired !== e.ret) begin
        errors++;
        $display("FAIL %s: ctl=%05h retired=%0d, expected ctl=%05h retired=%0d",
                 e.nm, act_ctl(), retired, e.ctl, e.ret);
      end
    end
  end

  task automatic cyc(input logic [31:0] ins, input logic mr, input logic bc,
                     input logic [19:0] ctl, input logic [3:0] ret,
                     input string nm);
    @(posedge clk);
    #1;
    instr = ins; mem_ready = mr; branch_cond = bc;
    sb_q.push_back('{ctl: ctl, ret: ret, nm: nm});
  endtask

  logic [19:0] ZERO, F_RDY, F_WAIT, EX_ADD, WB_ADD, EX_NOR, WB_NOR, EX_RORV,
               WB_RORV, MADR, MRD, MWB, MWR, BCMP, BT_T, BT_N, JMP, JRC,
               JAL, ILL, EXI, IWB;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_NOR  = 32'h0022_1827;
  localparam logic [31:0] I_RORV = 32'h0022_1806;
  localparam logic [31:0] I_LW   = 32'h8C24_0008;
  localparam logic [31:0] I_SW   = 32'hAC24_0008;
  localparam logic [31:0] I_BLEU = 32'h1022_0004;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_J    = 32'h0800_0040;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_NORI = 32'h3822_FFFF;
  localparam logic [31:0] I_BADO = 32'hFC00_0000;
  localparam logic [31:0] I_BADF = 32'h0000_003F;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    //          pcw iord irw a  b      pcs    jr j  rd m2r rwe mw alu       ill
    ZERO    = mk(0, 0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    F_RDY   = mk(1, 0,  1,  0, 2'b01, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    F_WAIT  = mk(0, 0,  0,  0, 2'b01, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    EX_ADD  = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    WB_ADD  = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 1, 0,  1,  0, 5'b00000, 0);
    EX_NOR  = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00010, 0);
    WB_NOR  = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 1, 0,  1,  0, 5'b00010, 0);
    EX_RORV = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00110, 0);
    WB_RORV = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 1, 0,  1,  0, 5'b00110, 0);
    MADR    = mk(0, 0,  0,  1, 2'b10, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    MRD     = mk(0, 1,  0,  1, 2'b10, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    MWB     = mk(0, 1,  0,  1, 2'b10, 2'b00, 0, 0, 0, 1,  1,  0, 5'b00000, 0);
    MWR     = mk(0, 1,  0,  1, 2'b10, 2'b00, 0, 0, 0, 0,  0,  1, 5'b00000, 0);
    BCMP    = mk(0, 0,  0,  1, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00111, 0);
    BT_T    = mk(1, 0,  0,  0, 2'b11, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    BT_N    = mk(0, 0,  0,  0, 2'b11, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    JMP     = mk(1, 0,  0,  0, 2'b00, 2'b10, 0, 0, 0, 0,  0,  0, 5'b00000, 0);
    JRC     = mk(1, 0,  0,  0, 2'b00, 2'b10, 1, 0, 0, 0,  0,  0, 5'b00000, 0);
    JAL     = mk(0, 0,  0,  0, 2'b00, 2'b00, 0, 1, 0, 0,  1,  0, 5'b01000, 0);
    ILL     = mk(0, 0,  0,  0, 2'b00, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00000, 1);
    EXI     = mk(0, 0,  0,  1, 2'b10, 2'b00, 0, 0, 0, 0,  0,  0, 5'b00100, 0);
    IWB     = mk(0, 0,  0,  1, 2'b10, 2'b00, 0, 0, 0, 0,  1,  0, 5'b00100, 0);

    reset_n = 1'b0; instr = '0; mem_ready = 1'b1; branch_cond = 1'b0;
    cyc('0, 1, 0, ZERO, 0, "reset_state");
    @(posedge clk); #1; reset_n = 1'b1;
    sb_q.push_back('{ctl: ZERO, ret: 4'd0, nm: "start_idle"});

    // add r3,r1,r2
    cyc(I_ADD, 1, 0, F_RDY,  0, "add_fetch");
    cyc(I_ADD, 1, 0, ZERO,   0, "add_decode");
    cyc(I_ADD, 0, 0, EX_ADD, 0, "add_exec");
    cyc(I_ADD, 0, 0, WB_ADD, 0, "add_wb");
    cyc(I_ADD, 0, 0, F_WAIT, 1, "add_retire_fetch_wait");
    // lw with three wait cycles in MEMRD
    cyc(I_LW, 1, 0, F_RDY, 1, "lw_fetch");
    cyc(I_LW, 0, 0, ZERO,  1, "lw_decode");
    cyc(I_LW, 0, 0, MADR,  1, "lw_memadr");
    for (int i = 0; i < 3; i++) cyc(I_LW, 0, 0, MRD, 1, "lw_memrd_wait");
    cyc(I_LW, 1, 0, MRD,   1, "lw_memrd_ready");
    cyc(I_LW, 0, 0, MWB,   1, "lw_memwb");
    cyc(I_LW, 0, 0, F_WAIT, 2, "lw_retire");
    // sw with one wait cycle
    cyc(I_SW, 1, 0, F_RDY, 2, "sw_fetch");
    cyc(I_SW, 0, 0, ZERO,  2, "sw_decode");
    cyc(I_SW, 0, 0, MADR,  2, "sw_memadr");
    cyc(I_SW, 0, 0, MWR,   2, "sw_memwr_wait");
    cyc(I_SW, 1, 0, MWR,   2, "sw_memwr_ready");
    cyc(I_SW, 0, 0, F_WAIT, 3, "sw_retire");
    // bleu taken; branch_cond flips after BR_CMP to show it is latched
    cyc(I_BLEU, 1, 0, F_RDY, 3, "bleu_t_fetch");
    cyc(I_BLEU, 0, 0, ZERO,  3, "bleu_t_decode");
    cyc(I_BLEU, 0, 1, BCMP,  3, "bleu_t_cmp");
    cyc(I_BLEU, 0, 0, BT_T,  3, "bleu_t_tgt");
    cyc(I_BLEU, 0, 0, F_WAIT, 4, "bleu_t_retire");
    // bleu not taken
    cyc(I_BLEU, 1, 1, F_RDY, 4, "bleu_n_fetch");
    cyc(I_BLEU, 0, 1, ZERO,  4, "bleu_n_decode");
    cyc(I_BLEU, 0, 0, BCMP,  4, "bleu_n_cmp");
    cyc(I_BLEU, 0, 1, BT_N,  4, "bleu_n_tgt");
    cyc(I_BLEU, 0, 0, F_WAIT, 5, "bleu_n_retire");
    // jal
    cyc(I_JAL, 1, 0, F_RDY, 5, "jal_fetch");
    cyc(I_JAL, 0, 0, ZERO,  5, "jal_decode");
    cyc(I_JAL, 1, 0, JAL,   5, "jal_link");
    cyc(I_JAL, 0, 0, JMP,   5, "jal_jump");
    cyc(I_JAL, 0, 0, F_WAIT, 6, "jal_retire");
    // jr
    cyc(I_JR, 1, 0, F_RDY, 6, "jr_fetch");
    cyc(I_JR, 0, 0, ZERO,  6, "jr_decode");
    cyc(I_JR, 0, 0, JRC,   6, "jr_exec");
    cyc(I_JR, 0, 0, F_WAIT, 7, "jr_retire");
    // nori
    cyc(I_NORI, 1, 0, F_RDY, 7, "nori_fetch");
    cyc(I_NORI, 0, 0, ZERO,  7, "nori_decode");
    cyc(I_NORI, 0, 0, EXI,   7, "nori_exec");
    cyc(I_NORI, 0, 0, IWB,   7, "nori_wb");
    cyc(I_NORI, 0, 0, F_WAIT, 8, "nori_retire");
    // undefined opcode: pulse, not retired
    cyc(I_BADO, 1, 0, F_RDY, 8, "badop_fetch");
    cyc(I_BADO, 0, 0, ZERO,  8, "badop_decode");
    cyc(I_BADO, 1, 0, ILL,   8, "badop_illegal");
    cyc(I_BADO, 0, 0, F_WAIT, 8, "badop_no_retire");
    // undefined funct
    cyc(I_BADF, 1, 0, F_RDY, 8, "badfn_fetch");
    cyc(I_BADF, 0, 0, ZERO,  8, "badfn_decode");
    cyc(I_BADF, 0, 0, ILL,   8, "badfn_illegal");
    cyc(I_BADF, 0, 0, F_WAIT, 8, "badfn_no_retire");
    // nor and rorv funct decode
    cyc(I_NOR, 1, 0, F_RDY,  8, "nor_fetch");
    cyc(I_NOR, 0, 0, ZERO,   8, "nor_decode");
    cyc(I_NOR, 0, 0, EX_NOR, 8, "nor_exec");
    cyc(I_NOR, 0, 0, WB_NOR, 8, "nor_wb");
    cyc(I_RORV, 1, 0, F_RDY,   9, "rorv_fetch");
    cyc(I_RORV, 0, 0, ZERO,    9, "rorv_decode");
    cyc(I_RORV, 0, 0, EX_RORV, 9, "rorv_exec");
    cyc(I_RORV, 0, 0, WB_RORV, 9, "rorv_wb");
    // j
    cyc(I_J, 1, 0, F_RDY, 10, "j_fetch");
    cyc(I_J, 0, 0, ZERO,  10, "j_decode");
    cyc(I_J, 0, 0, JMP,   10, "j_jump");
    // five adds: retired walks 11..15 then wraps to 0
    for (int i = 0; i < 5; i++) begin
      cyc(I_ADD, 1, 0, F_RDY,  4'(11 + i), "wrap_fetch");
      cyc(I_ADD, 0, 0, ZERO,   4'(11 + i), "wrap_decode");
      cyc(I_ADD, 0, 0, EX_ADD, 4'(11 + i), "wrap_exec");
      cyc(I_ADD, 0, 0, WB_ADD, 4'(11 + i), "wrap_wb");
    end
    cyc(I_ADD, 0, 0, F_WAIT, 0, "retired_wrap");
    // reset in the middle of a store
    cyc(I_SW, 1, 0, F_RDY, 0, "rst_sw_fetch");
    cyc(I_SW, 0, 0, ZERO,  0, "rst_sw_decode");
    cyc(I_SW, 0, 0, MADR,  0, "rst_sw_memadr");
    cyc(I_SW, 0, 0, MWR,   1'b0 ? 4'd1 : 4'd0, "rst_sw_memwr");
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (memWrite !== 1'b0 || act_ctl() !== ZERO || retired !== 4'd0) begin
      errors++;
      $display("FAIL rst_async_drop: memWrite=%b ctl=%05h retired=%0d, expected memWrite=0 ctl=%05h retired=0",
               memWrite, act_ctl(), retired, ZERO);
    end
    cyc(I_SW, 1, 0, ZERO, 0, "rst_held");
    @(posedge clk); #1; reset_n = 1'b1;
    sb_q.push_back('{ctl: ZERO, ret: 4'd0, nm: "rst_start"});
    cyc(I_SW, 0, 0, F_WAIT, 0, "rst_fetch");

    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
